// File: rtl/eeprom_pkg.sv
// Shared opcodes, status bit positions and FSM states for the SPI EEPROM responder.
package eeprom_pkg;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam int ST_WIP = 0;
  localparam int ST_WEL = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPC,
    S_ADDR,
    S_RDATA,
    S_RDSR,
    S_WDATA,
    S_IGNORE
  } state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronisers for CS/SCK/MOSI plus edge detection on CS and SCK.
// Edges are taken between the second sync stage and one extra history flop,
// so MOSI (two stages) stays aligned with the detected SCK edge.
module spi_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic cs_i,
  input  logic sck_i,
  input  logic din_i,
  output logic cs_fall_o,
  output logic cs_rise_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic din_o
);

  logic [2:0] cs_q, cs_d;
  logic [2:0] sck_q, sck_d;
  logic [1:0] din_q, din_d;

  // Shift each raw input into its synchroniser chain.
  always_comb begin
    cs_d  = {cs_q[1:0], cs_i};
    sck_d = {sck_q[1:0], sck_i};
    din_d = {din_q[0], din_i};
  end

  // Chains reset to the bus idle levels (CS high, SCK low) to avoid false edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q  <= 3'b111;
      sck_q <= 3'b000;
      din_q <= 2'b00;
    end else begin
      cs_q  <= cs_d;
      sck_q <= sck_d;
      din_q <= din_d;
    end
  end

  assign cs_fall_o  = cs_q[2] & ~cs_q[1];
  assign cs_rise_o  = ~cs_q[2] & cs_q[1];
  assign sck_rise_o = ~sck_q[2] & sck_q[1];
  assign sck_fall_o = sck_q[2] & ~sck_q[1];
  assign din_o      = din_q[1];

endmodule

// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 responder emulating a 25xx-class EEPROM backed by a byte array.
// Handshake: wr_pulse is a single-cycle strobe; wr_addr/wr_data are valid in
// that cycle and hold their last value afterwards. There is no backpressure.
module spi_eeprom_responder
  import eeprom_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int PAGE_W = 4,
  parameter int T_WC   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs,
  input  logic              spi_sck,
  input  logic              spi_din,
  output logic              spi_dout,
  output logic              spi_dout_oe,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [7:0]        status,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [7:0]        host_rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  // Shift register plus incoming bit must cover both an opcode and the implemented address bits.
  localparam int SI_W = (ADDR_W > 8) ? ADDR_W : 8;
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((1 << PAGE_W) - 1);
  localparam logic [15:0] WC_LOAD = 16'(T_WC);

  logic cs_fall, cs_rise, sck_rise, sck_fall, din_s;

  spi_in_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .cs_i       (spi_cs),
    .sck_i      (spi_sck),
    .din_i      (spi_din),
    .cs_fall_o  (cs_fall),
    .cs_rise_o  (cs_rise),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .din_o      (din_s)
  );

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [SI_W-2:0]   shift_q, shift_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wel_q, wel_d;
  logic              wip_q, wip_d;
  logic [15:0]       wip_cnt_q, wip_cnt_d;
  logic              is_wr_q, is_wr_d;
  logic              wrote_q, wrote_d;
  logic [6:0]        tx_sh_q, tx_sh_d;
  logic [2:0]        tx_cnt_q, tx_cnt_d;
  logic              dout_q, dout_d;
  logic              oe_q, oe_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        host_rdata_q;

  logic [7:0]        mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  logic [SI_W-1:0]   shift_in;
  logic [7:0]        byte_in;
  logic [7:0]        status_w;
  logic [7:0]        load_byte;

  assign shift_in = {shift_q, din_s};
  assign byte_in  = shift_in[7:0];

  // Status byte and the next byte to serialise on MISO (status or array data).
  always_comb begin
    status_w         = '0;
    status_w[ST_WEL] = wel_q;
    status_w[ST_WIP] = wip_q;
    load_byte        = (state_q == S_RDSR) ? status_w : mem[ptr_q];
  end

  // Next-state and datapath logic: command decode, address capture, read/write phases.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    wel_d      = wel_q;
    wip_d      = wip_q;
    wip_cnt_d  = wip_cnt_q;
    is_wr_d    = is_wr_q;
    wrote_d    = wrote_q;
    tx_sh_d    = tx_sh_q;
    tx_cnt_d   = tx_cnt_q;
    dout_d     = dout_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = byte_in;

    // Write-cycle busy countdown runs independently of the bus.
    if (wip_q) begin
      if (wip_cnt_q <= 16'd1) begin
        wip_d     = 1'b0;
        wip_cnt_d = '0;
      end else begin
        wip_cnt_d = wip_cnt_q - 16'd1;
      end
    end

    if (cs_fall) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (sck_rise) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
      shift_d   = shift_in[SI_W-2:0];
    end

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d  = S_OPC;
          wrote_d  = 1'b0;
          tx_cnt_d = '0;
        end
      end
      S_OPC: begin
        if (sck_rise && bit_cnt_q == 4'd7) begin
          bit_cnt_d = '0;
          if (wip_q && byte_in != OP_RDSR) begin
            state_d = S_IGNORE;
          end else begin
            case (byte_in)
              OP_WREN: begin
                wel_d   = 1'b1;
                state_d = S_IGNORE;
              end
              OP_WRDI: begin
                wel_d   = 1'b0;
                state_d = S_IGNORE;
              end
              OP_RDSR: begin
                state_d  = S_RDSR;
                tx_cnt_d = '0;
              end
              OP_READ: begin
                state_d = S_ADDR;
                is_wr_d = 1'b0;
              end
              OP_WRITE: begin
                state_d = wel_q ? S_ADDR : S_IGNORE;
                is_wr_d = 1'b1;
              end
              default: state_d = S_IGNORE;
            endcase
          end
        end
      end
      S_ADDR: begin
        if (sck_rise && bit_cnt_q == 4'd15) begin
          bit_cnt_d = '0;
          ptr_d     = shift_in[ADDR_W-1:0];
          tx_cnt_d  = '0;
          state_d   = is_wr_q ? S_WDATA : S_RDATA;
        end
      end
      S_RDATA, S_RDSR: begin
        // A new byte is fetched on the first fall of each 8-bit group.
        if (sck_fall) begin
          if (tx_cnt_q == 3'd0) begin
            dout_d  = load_byte[7];
            tx_sh_d = load_byte[6:0];
            if (state_q == S_RDATA) ptr_d = ptr_q + ADDR_W'(1);
          end else begin
            dout_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[5:0], 1'b0};
          end
          tx_cnt_d = tx_cnt_q + 3'd1;
        end
      end
      S_WDATA: begin
        if (sck_rise && bit_cnt_q == 4'd7) begin
          bit_cnt_d  = '0;
          mem_we     = 1'b1;
          wr_pulse_d = 1'b1;
          wr_addr_d  = ptr_q;
          wr_data_d  = byte_in;
          wrote_d    = 1'b1;
          ptr_d      = (ptr_q & ~PAGE_MASK) | ((ptr_q + ADDR_W'(1)) & PAGE_MASK);
        end
      end
      S_IGNORE: ;
      default: state_d = S_IDLE;
    endcase

    // CS rise ends the frame and wins over any byte completing in the same cycle.
    if (cs_rise) begin
      state_d    = S_IDLE;
      dout_d     = 1'b0;
      mem_we     = 1'b0;
      wr_pulse_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      ptr_d      = ptr_q;
      wel_d      = wel_q;
      if (state_q == S_WDATA && wrote_q) begin
        wel_d = 1'b0;
        if (T_WC > 0) begin
          wip_d     = 1'b1;
          wip_cnt_d = WC_LOAD;
        end
      end
    end

    oe_d = (state_d == S_RDATA) || (state_d == S_RDSR);
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      wel_q      <= 1'b0;
      wip_q      <= 1'b0;
      wip_cnt_q  <= '0;
      is_wr_q    <= 1'b0;
      wrote_q    <= 1'b0;
      tx_sh_q    <= '0;
      tx_cnt_q   <= '0;
      dout_q     <= 1'b0;
      oe_q       <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      wel_q      <= wel_d;
      wip_q      <= wip_d;
      wip_cnt_q  <= wip_cnt_d;
      is_wr_q    <= is_wr_d;
      wrote_q    <= wrote_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Byte array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Backdoor read port; a same-cycle commit to the same address returns the old byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) host_rdata_q <= '0;
    else     host_rdata_q <= mem[host_addr];
  end

  assign spi_dout    = dout_q;
  assign spi_dout_oe = oe_q;
  assign wr_pulse    = wr_pulse_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign status      = status_w;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Bench for spi_eeprom_responder: SPI master driver tasks, a behavioural EEPROM
// model, and two monitors (write strobes and MISO bytes) popping expected queues.
module tb_spi_eeprom_responder;
  import eeprom_pkg::*;

  localparam int ADDR_W = 8;
  localparam int PAGE_W = 4;
  localparam int PAGE   = 1 << PAGE_W;
  localparam int T_WC   = 400;
  localparam int H      = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, spi_cs, spi_sck, spi_din;
  logic spi_dout, spi_dout_oe, wr_pulse;
  logic [ADDR_W-1:0] wr_addr, host_addr;
  logic [7:0] wr_data, status, host_rdata;

  always #5 clk = ~clk;

  spi_eeprom_responder #(.ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .T_WC(T_WC)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs      (spi_cs),
    .spi_sck     (spi_sck),
    .spi_din     (spi_din),
    .spi_dout    (spi_dout),
    .spi_dout_oe (spi_dout_oe),
    .wr_pulse    (wr_pulse),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .status      (status),
    .host_addr   (host_addr),
    .host_rdata  (host_rdata)
  );

  // ---------------- scoreboard state / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [ADDR_W+7:0] exp_wr_q[$];
  logic [7:0]        exp_rd_q[$];
  logic [7:0]        wbytes[$];
  logic [7:0]        ref_mem[1 << ADDR_W];
  bit                m_wel = 1'b0;
  bit                m_wip = 1'b0;
  logic [7:0]        rx_sh = '0;
  int                rx_cnt = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int page_next(input int p);
    return (p / PAGE) * PAGE + ((p % PAGE) + 1) % PAGE;
  endfunction

  function automatic logic [7:0] model_status();
    return {6'b0, m_wel, m_wip};
  endfunction

  // ---------------- monitors ----------------
  // Every write strobe must match the next expected commit.
  always @(negedge clk) begin
    if (rst === 1'b0 && wr_pulse === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        chk("wr_unexpected", {wr_addr, wr_data}, 16'hxxxx);
      end else begin
        chk("wr_commit", {wr_addr, wr_data}, exp_wr_q.pop_front());
      end
    end
  end

  // Master-side MISO capture on SCK rise during an enabled data phase.
  always @(posedge spi_sck) begin
    if (spi_dout_oe !== 1'b1) begin
      rx_cnt = 0;
    end else begin
      rx_sh  = {rx_sh[6:0], spi_dout};
      rx_cnt = rx_cnt + 1;
      if (rx_cnt == 8) begin
        rx_cnt = 0;
        if (exp_rd_q.size() == 0) chk("miso_unexpected", {8'h00, rx_sh}, 16'hxxxx);
        else                      chk("miso_byte", {8'h00, rx_sh}, {8'h00, exp_rd_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high();
    wait_clk(H);
    spi_cs  = 1'b1;
    spi_din = 1'b0;
    wait_clk(3 * H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_din = b[7-i];
      wait_clk(H);
      spi_sck = 1'b1;
      wait_clk(H);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cmd(input logic [7:0] op);
    cs_low();
    send_bits(op, 8);
    cs_high();
    if (!m_wip) begin
      if (op == OP_WREN) m_wel = 1'b1;
      if (op == OP_WRDI) m_wel = 1'b0;
    end
  endtask

  task automatic do_write(input logic [15:0] a);
    int n;
    int p;
    bit ok;
    logic [7:0] b;
    n  = wbytes.size();
    ok = m_wel && !m_wip;
    p  = int'(a[ADDR_W-1:0]);
    cs_low();
    send_bits(OP_WRITE, 8);
    send_bits(a[15:8], 8);
    send_bits(a[7:0], 8);
    for (int i = 0; i < n; i++) begin
      b = wbytes.pop_front();
      if (ok) begin
        exp_wr_q.push_back({ADDR_W'(p), b});
        ref_mem[p] = b;
        p = page_next(p);
      end
      send_bits(b, 8);
    end
    cs_high();
    if (ok && n > 0) begin
      m_wel = 1'b0;
      m_wip = (T_WC > 0);
    end
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    bit act;
    act = !m_wip;
    cs_low();
    send_bits(OP_READ, 8);
    chk("oe_opcode", {15'b0, spi_dout_oe}, 16'h0000);
    send_bits(a[15:8], 8);
    send_bits(a[7:0], 8);
    chk("oe_data", {15'b0, spi_dout_oe}, {15'b0, act});
    if (act) begin
      for (int i = 0; i < n; i++) exp_rd_q.push_back(ref_mem[(int'(a[ADDR_W-1:0]) + i) % (1 << ADDR_W)]);
    end
    for (int i = 0; i < n; i++) send_bits(8'h00, 8);
    cs_high();
    chk("oe_end", {15'b0, spi_dout_oe}, 16'h0000);
    chk("dout_end", {15'b0, spi_dout}, 16'h0000);
  endtask

  task automatic do_rdsr(input int n);
    cs_low();
    send_bits(OP_RDSR, 8);
    for (int i = 0; i < n; i++) exp_rd_q.push_back(model_status());
    for (int i = 0; i < n; i++) send_bits(8'h00, 8);
    cs_high();
  endtask

  task automatic wait_idle();
    if (m_wip) begin
      wait_clk(T_WC + 10);
      m_wip = 1'b0;
    end
  endtask

  task automatic status_check(input string name);
    chk(name, {8'h00, status}, {8'h00, model_status()});
  endtask

  task automatic host_check(input logic [ADDR_W-1:0] a);
    host_addr = a;
    wait_clk(2);
    chk("host_rdata", {8'h00, host_rdata}, {8'h00, ref_mem[a]});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  hi;
    logic [15:0] a;
    int op;
    int n;

    rst = 1'b1; spi_cs = 1'b1; spi_sck = 1'b0; spi_din = 1'b0; host_addr = '0;
    wait_clk(5);
    chk("rst_dout",  {15'b0, spi_dout}, 16'h0000);
    chk("rst_oe",    {15'b0, spi_dout_oe}, 16'h0000);
    chk("rst_wr",    {15'b0, wr_pulse}, 16'h0000);
    chk("rst_waddr", {8'h00, wr_addr}, 16'h0000);
    chk("rst_wdata", {8'h00, wr_data}, 16'h0000);
    chk("rst_status", {8'h00, status}, 16'h0000);
    chk("rst_hrdata", {8'h00, host_rdata}, 16'h0000);
    rst = 1'b0;
    wait_clk(5);

    // Fill the whole array with random page writes (upper address byte random).
    for (int p = 0; p < (1 << ADDR_W) / PAGE; p++) begin
      cmd(OP_WREN);
      for (int i = 0; i < PAGE; i++) wbytes.push_back(8'($urandom_range(0, 255)));
      hi = 8'($urandom_range(0, 255));
      do_write({hi, 8'(p * PAGE)});
      wait_idle();
    end

    // Basic write of two bytes, then status.
    cmd(OP_WREN);
    status_check("st_wel_set");
    wbytes.push_back(8'hA5); wbytes.push_back(8'h3C);
    do_write(16'h0012);
    wait_idle();
    status_check("st_after_write");
    do_rdsr(1);

    // Read them back.
    do_read(16'h0012, 2);

    // Write without WREN is ignored.
    wbytes.push_back(8'h55);
    do_write(16'h0020);
    host_check(8'h20);
    status_check("st_no_wren");

    // WREN then WRDI.
    cmd(OP_WREN);
    cmd(OP_WRDI);
    status_check("st_wrdi");

    // Page wrap on write, array wrap on read.
    cmd(OP_WREN);
    wbytes.push_back(8'h11); wbytes.push_back(8'h22);
    do_write(16'h001F);
    wait_idle();
    host_check(8'h10);
    do_read(16'h00FF, 2);

    // Busy period: RDSR shows WIP, WREN ignored while busy.
    cmd(OP_WREN);
    wbytes.push_back(8'h77);
    do_write(16'h0005);
    status_check("st_busy");
    do_rdsr(1);
    cmd(OP_WREN);
    status_check("st_busy_wren");
    wait_idle();
    do_rdsr(1);
    status_check("st_idle_again");

    // Partial data byte and address abort keep WEL and commit nothing.
    cmd(OP_WREN);
    cs_low();
    send_bits(OP_WRITE, 8); send_bits(8'h00, 8); send_bits(8'h30, 8);
    send_bits(8'hC3, 5);
    cs_high();
    status_check("st_partial");
    host_check(8'h30);
    cs_low();
    send_bits(OP_WRITE, 8); send_bits(8'h00, 8);
    cs_high();
    status_check("st_addr_abort");

    // Reset mid-read.
    cs_low();
    send_bits(OP_READ, 8); send_bits(8'h00, 8); send_bits(8'h40, 8);
    send_bits(8'h00, 3);
    rst = 1'b1;
    #1;
    m_wel = 1'b0;
    m_wip = 1'b0;
    chk("rst_mid_oe", {15'b0, spi_dout_oe}, 16'h0000);
    status_check("rst_mid_status");
    wait_clk(3);
    spi_cs = 1'b1; spi_sck = 1'b0; spi_din = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);
    host_check(8'h40);
    do_read(16'h0040, 1);

    // Randomised mix of operations against the model.
    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 5);
      a  = 16'($urandom_range(0, 65535));
      case (op)
        0, 1: begin
          if (op == 0) cmd(OP_WREN);
          n = $urandom_range(1, 6);
          for (int i = 0; i < n; i++) wbytes.push_back(8'($urandom_range(0, 255)));
          do_write(a);
          status_check("st_rand_write");
          wait_idle();
        end
        2: do_read(a, $urandom_range(1, 4));
        3: do_rdsr($urandom_range(1, 2));
        4: begin
          case ($urandom_range(0, 2))
            0:       cmd(OP_WREN);
            1:       cmd(OP_WRDI);
            default: cmd(8'hAB);
          endcase
          status_check("st_rand_cmd");
        end
        default: host_check(a[ADDR_W-1:0]);
      endcase
    end

    wait_clk(20);
    chk("wr_queue_empty", 16'(exp_wr_q.size()), 16'h0000);
    chk("rd_queue_empty", 16'(exp_rd_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
